// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting and a first-word-fall-through receive FIFO.
// Define UART_RX_TIMEOUT_EN to enable the idle-timeout counter that drives rx_timeout.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop_bits,
  input  logic              uart_rxd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              out_ferr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              rx_timeout
);

  // state    | meaning
  // IDLE     | line idle, waiting for a low level
  // START    | validating the start bit, glitches return to IDLE
  // DATA     | shifting in DATA_W bits, LSB first
  // PARITY   | checking the parity bit
  // STOP1    | first stop bit, push here for one stop bit
  // STOP2    | second stop bit, push here
  // BRK_WAIT | line still low after the frame, wait for it to go high
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;
  localparam logic [2:0] S_BRK    = 3'd6;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              rx_meta_q, rxs_q;
  logic [2:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       b_q, b_d;
  logic [1:0]        par_q, par_d;
  logic              stop2_q, stop2_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              v0_q, v0_d, v1_q, v1_d;
  logic              perr_q, perr_d, ferr_q, ferr_d;
  logic              push;
  logic [EW-1:0]     push_entry;

  logic [15:0] mid;
  logic        bit_end, is_s0, is_s1, is_dec, maj;

  assign mid     = {1'b0, b_q[15:1]};
  assign bit_end = (cnt_q == b_q - 16'd1);
  assign is_s0   = (cnt_q == mid - 16'd1);
  assign is_s1   = (cnt_q == mid);
  assign is_dec  = (cnt_q == mid + 16'd1);
  assign maj     = (v0_q & v1_q) | (v0_q & rxs_q) | (v1_q & rxs_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    b_d        = b_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    bit_idx_d  = bit_idx_q;
    sh_d       = sh_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    push       = 1'b0;
    push_entry = '0;

    if (state_q == S_IDLE || state_q == S_BRK) begin
      cnt_d = '0;
    end else begin
      cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
      if (is_s0) v0_d = rxs_q;
      if (is_s1) v1_d = rxs_q;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d   = S_START;
          b_d       = (baud_div < 16'd4) ? 16'd4 : baud_div;
          par_d     = parity_mode;
          stop2_d   = stop_bits;
          bit_idx_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      S_START: begin
        if (is_dec && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (is_dec) sh_d = {maj, sh_q[DATA_W-1:1]};
        if (bit_end) begin
          if (bit_idx_q == IW'(DATA_W - 1)) begin
            state_d = (par_q == 2'd1 || par_q == 2'd2) ? S_PARITY : S_STOP1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (is_dec) perr_d = (^sh_q) ^ maj ^ (par_q == 2'd2);
        if (bit_end) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (is_dec) begin
          if (!maj) ferr_d = 1'b1;
          if (!stop2_q) begin
            push       = 1'b1;
            push_entry = {ferr_q | ~maj, perr_q, sh_q};
            state_d    = rxs_q ? S_IDLE : S_BRK;
            cnt_d      = '0;
          end
        end
        if (bit_end && stop2_q) state_d = S_STOP2;
      end
      S_STOP2: begin
        if (is_dec) begin
          push       = 1'b1;
          push_entry = {ferr_q | ~maj, perr_q, sh_q};
          state_d    = rxs_q ? S_IDLE : S_BRK;
          cnt_d      = '0;
        end
      end
      S_BRK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      b_q       <= 16'd4;
      par_q     <= '0;
      stop2_q   <= 1'b0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      v0_q      <= 1'b1;
      v1_q      <= 1'b1;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= uart_rxd;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      b_q       <= b_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ovr_q;
  logic             full, pop, do_push, drop;
  logic [EW-1:0]    head;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop)         ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? head[DATA_W-1:0] : '0;
  assign out_perr   = out_valid & head[DATA_W];
  assign out_ferr   = out_valid & head[DATA_W+1];
  assign fifo_count = count_q;
  assign overrun    = ovr_q;

`ifdef UART_RX_TIMEOUT_EN
  logic [20:0] to_cnt_q;
  logic [20:0] to_lim;
  logic        to_flag_q;
  logic        start_edge;

  assign to_lim     = {b_q, 5'b0};
  assign start_edge = (state_q == S_IDLE) && !rxs_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else if (start_edge || pop || !out_valid) begin
      to_cnt_q <= '0;
      if (start_edge || pop) to_flag_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (to_cnt_q != to_lim) to_cnt_q <= to_cnt_q + 21'd1;
      if (to_cnt_q == to_lim - 21'd1) to_flag_q <= 1'b1;
    end
  end

  assign rx_timeout = to_flag_q;
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame-level model of expected FIFO entries,
// a per-cycle head compare, and directed literal checks.
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   baud_div;
  logic [1:0]    parity_mode;
  logic          stop_bits;
  logic          uart_rxd;
  logic [DW-1:0] out_data;
  logic          out_perr, out_ferr, out_valid, out_ready;
  logic [CW-1:0] fifo_count;
  logic          overrun, ovr_clr, rx_timeout;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop_bits(stop_bits), .uart_rxd(uart_rxd), .out_data(out_data),
    .out_perr(out_perr), .out_ferr(out_ferr), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .overrun(overrun),
    .ovr_clr(ovr_clr), .rx_timeout(rx_timeout)
  );

  typedef struct packed {
    logic          ferr;
    logic          perr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t exp_q[$];
  logic model_ovr;
  int   bclk;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v);
    uart_rxd = v;
    tick(bclk);
  endtask

  task automatic model_push(input ent_t e);
    if (exp_q.size() >= DEPTH) model_ovr = 1'b1;
    else exp_q.push_back(e);
  endtask

  // pforce < 0 sends the correct parity bit, otherwise pforce[0]
  task automatic send_frame(input logic [DW-1:0] d, input logic [1:0] pm, input logic two,
                            input int pforce, input logic s0, input logic s1, input logic tail);
    logic x, pbit, pe, fe;
    ent_t e;
    x    = ^d;
    pbit = (pforce >= 0) ? pforce[0] : ((pm == 2'd2) ? ~x : x);
    pe   = (pm == 2'd1) ? (x ^ pbit) : (pm == 2'd2) ? ~(x ^ pbit) : 1'b0;
    fe   = ~s0 | (two & ~s1);
    e    = ent_t'({fe, pe, d});
    parity_mode = pm;
    stop_bits   = two;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (pm == 2'd1 || pm == 2'd2) send_bit(pbit);
    if (two) send_bit(s0);
    model_push(e);
    send_bit(two ? s1 : s0);
    if (tail) send_bit(1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 200) begin
      tick(1);
      n++;
    end
    out_ready = 1'b0;
    if (n >= 200) check("drain_timeout", 32'(n), 32'(0));
    check("drain_model_empty", 32'(exp_q.size()), 32'(0));
  endtask

  // Head of the DUT FIFO must always equal the oldest entry the model still holds.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_entry", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        check("head", 32'({out_ferr, out_perr, out_data}), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [DW-1:0] rd;
    rst_n = 1'b0; uart_rxd = 1'b1; out_ready = 1'b0; ovr_clr = 1'b0;
    baud_div = 16'd16; parity_mode = 2'd0; stop_bits = 1'b0;
    bclk = 16; model_ovr = 1'b0;
    tick(3);
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_count", 32'(fifo_count), 32'(0));
    check("rst_data", 32'(out_data), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    check("rst_timeout", 32'(rx_timeout), 32'(0));
    rst_n = 1'b1;
    tick(5);

    lat = 0;
    fork
      send_frame(8'hA5, 2'd0, 1'b0, -1, 1'b1, 1'b1, 1'b1);
      begin
        while (!out_valid && lat < 400) begin
          tick(1);
          lat++;
        end
      end
    join
    check("latency_in_window", 32'(lat >= 140 && lat <= 160), 32'(1));
    check("a5_data", 32'(out_data), 32'hA5);
    check("a5_perr", 32'(out_perr), 32'(0));
    check("a5_ferr", 32'(out_ferr), 32'(0));
    check("a5_count", 32'(fifo_count), 32'(1));
    drain();

    send_frame(8'h12, 2'd1, 1'b0, 1, 1'b1, 1'b1, 1'b1);
    check("even_data", 32'(out_data), 32'h12);
    check("even_perr", 32'(out_perr), 32'(1));
    drain();
    send_frame(8'h88, 2'd2, 1'b0, 1, 1'b1, 1'b1, 1'b1);
    check("odd_data", 32'(out_data), 32'h88);
    check("odd_perr", 32'(out_perr), 32'(0));
    drain();

    send_frame(8'h5A, 2'd0, 1'b1, -1, 1'b1, 1'b0, 1'b1);
    check("stop2_ferr", 32'(out_ferr), 32'(1));
    send_frame(8'hE7, 2'd2, 1'b1, -1, 1'b1, 1'b1, 1'b1);
    check("two_count", 32'(fifo_count), 32'(exp_q.size()));
    drain();

    baud_div = 16'd2; bclk = 4;
    send_frame(8'h96, 2'd1, 1'b0, -1, 1'b1, 1'b1, 1'b1);
    check("minbaud_data", 32'(out_data), 32'h96);
    drain();
    baud_div = 16'd16; bclk = 16;

    send_frame(8'h55, 2'd0, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    uart_rxd = 1'b0;
    tick(40 * bclk);
    check("brk_count", 32'(fifo_count), 32'(1));
    check("brk_ferr", 32'(out_ferr), 32'(1));
    check("brk_data", 32'(out_data), 32'h55);
    uart_rxd = 1'b1;
    tick(2 * bclk);
    send_frame(8'h3C, 2'd0, 1'b0, -1, 1'b1, 1'b1, 1'b1);
    check("after_brk_count", 32'(fifo_count), 32'(2));
    drain();

    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    tick(3 * bclk);
    check("glitch_count", 32'(fifo_count), 32'(0));
    send_frame(8'h81, 2'd0, 1'b0, -1, 1'b1, 1'b1, 1'b1);
    check("post_glitch_data", 32'(out_data), 32'h81);
    drain();

    for (int i = 0; i <= 16; i++) send_frame(8'(i), 2'd0, 1'b0, -1, 1'b1, 1'b1, 1'b1);
    check("full_count", 32'(fifo_count), 32'(16));
    check("full_overrun", 32'(overrun), 32'(1));
    check("model_overrun", 32'(overrun), 32'(model_ovr));
    check("full_head", 32'(out_data), 32'h00);
    drain();
    check("ovr_sticky", 32'(overrun), 32'(1));
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    model_ovr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'(0));

    send_frame(8'h11, 2'd0, 1'b0, -1, 1'b1, 1'b1, 1'b1);
    rd = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(rd[i]);
    uart_rxd = rd[3];
    tick(6);
    rst_n = 1'b0;
    uart_rxd = 1'b1;
    exp_q.delete();
    tick(1);
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_count", 32'(fifo_count), 32'(0));
    check("mid_rst_data", 32'(out_data), 32'(0));
    check("mid_rst_flags", 32'({out_perr, out_ferr, overrun, rx_timeout}), 32'(0));
    rst_n = 1'b1;
    tick(2 * bclk);
    send_frame(8'hC3, 2'd0, 1'b0, -1, 1'b1, 1'b1, 1'b1);
    check("c3_entry", 32'({out_ferr, out_perr, out_data}), 32'h0C3);
    check("c3_count", 32'(fifo_count), 32'(1));

    tick(400);
    check("timeout_early", 32'(rx_timeout), 32'(0));
    tick(120);
`ifdef UART_RX_TIMEOUT_EN
    check("timeout_set", 32'(rx_timeout), 32'(1));
`else
    check("timeout_tied", 32'(rx_timeout), 32'(0));
`endif
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("timeout_after_pop", 32'(rx_timeout), 32'(0));
    check("final_count", 32'(fifo_count), 32'(exp_q.size()));

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
